rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Produces a registered one-hot grant vector (3-to-8 decoded) plus the binary grant index.
- Owners may lock the resource, bounded by an optional hold timeout.
- Sits between requester logic and the shared datapath select (mux/enable decode).

---
 rtl/rr_arbiter_8.sv | 131 +++++++++++++
 tb/tb_rr_arbiter_8.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with registered one-hot grant,
// binary grant index and an optional per-ownership hold timeout.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam bit         HOLD_EN  = (MAX_HOLD != 0);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_ptr,   w_ptr_nxt;
    logic [7:0] r_hold,  w_hold_nxt;
    logic [7:0] r_gnt,   w_gnt_nxt;
    logic [2:0] r_idx,   w_idx_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_pre,   w_pre_nxt;

    logic [2:0] w_win;
    logic       w_any;
    logic       w_own_req;
    logic       w_timeout;
    logic [7:0] w_hold_inc;

    // Cyclic priority search starting at r_ptr; first set request wins.
    // After any grant r_ptr = owner+1, so the owner is automatically lowest.
    always_comb begin
        logic [2:0] cand;
        logic       found;
        w_win = r_ptr;
        found = 1'b0;
        cand  = r_ptr;
        for (int k = 0; k < 8; k++) begin
            cand = r_ptr + 3'(k);
            if (!found && req[cand]) begin
                w_win = cand;
                found = 1'b1;
            end
        end
    end

    assign w_any      = |req;
    assign w_own_req  = req[r_idx];
    assign w_timeout  = HOLD_EN && (r_hold == HOLD_LIM);
    assign w_hold_inc = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;

    // Next-state and output decode: grant, release hand-off, timeout, hold.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_pre_nxt   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = 8'd1 << w_win;
                    w_idx_nxt   = w_win;
                    w_valid_nxt = 1'b1;
                    w_ptr_nxt   = w_win + 3'd1;
                    w_hold_nxt  = 8'd1;
                end
            end
            S_GRANT: begin
                if (!w_own_req) begin
                    // Release: hand off in the same edge, or drop to idle.
                    if (w_any) begin
                        w_gnt_nxt   = 8'd1 << w_win;
                        w_idx_nxt   = w_win;
                        w_ptr_nxt   = w_win + 3'd1;
                        w_hold_nxt  = 8'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = 8'h00;
                        w_valid_nxt = 1'b0;
                    end
                end else if (w_timeout) begin
                    // Forced rotation; may re-grant the same owner if alone.
                    w_gnt_nxt  = 8'd1 << w_win;
                    w_idx_nxt  = w_win;
                    w_ptr_nxt  = w_win + 3'd1;
                    w_hold_nxt = 8'd1;
                    w_pre_nxt  = 1'b1;
                end else begin
                    w_hold_nxt = w_hold_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'd0;
            r_hold  <= 8'd0;
            r_gnt   <= 8'h00;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
            r_pre   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_pre   <= w_pre_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
    assign preempt   = r_pre;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8 (MAX_HOLD=4): vector table, a latency sequence,
// and randomized traffic against a behavioural reference model.
module tb_rr_arbiter_8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_tot  = 0;
    int n_pass = 0;

    rr_arbiter_8 #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       v;
        logic       p;
    } vec_t;

    vec_t tbl[$];

    // Grant vector must never be multi-hot.
    always @(negedge clk) begin
        n_tot++;
        assert ($onehot0(gnt)) n_pass++;
        else $display("FAIL onehot gnt=%h", gnt);
    end

    task automatic chk(input string nm, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic ep);
        n_tot++;
        if (gnt === eg && gnt_idx === ei && gnt_valid === ev && preempt === ep)
            n_pass++;
        else
            $display("FAIL %s got gnt=%h idx=%0d v=%b p=%b want gnt=%h idx=%0d v=%b p=%b",
                     nm, gnt, gnt_idx, gnt_valid, preempt, eg, ei, ev, ep);
    endtask

    task automatic step(input logic r, input logic [7:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    bit       m_valid;
    int       m_owner, m_ptr, m_hold;
    bit       m_pre;

    function automatic int pick(input logic [7:0] q, input int p);
        int best = -1, bd = 99;
        for (int i = 0; i < 8; i++)
            if (q[i] && ((i - p + 8) % 8) < bd) begin
                bd   = (i - p + 8) % 8;
                best = i;
            end
        return best;
    endfunction

    task automatic m_grant(input int w);
        m_owner = w;
        m_valid = 1;
        m_ptr   = (w + 1) % 8;
        m_hold  = 1;
    endtask

    task automatic m_step(input logic r, input logic [7:0] q);
        m_pre = 0;
        if (r) begin
            m_valid = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        end else if (!m_valid) begin
            if (q != 0) m_grant(pick(q, m_ptr));
        end else if (!q[m_owner]) begin
            if (q != 0) m_grant(pick(q, m_ptr));
            else m_valid = 0;
        end else if (m_hold == HOLD) begin
            m_grant(pick(q, (m_owner + 1) % 8));
            m_pre = 1;
        end else if (m_hold < 255) begin
            m_hold++;
        end
    endtask

    initial begin
        logic [7:0] rq;
        logic       rr;

        rst = 1'b1;
        req = 8'h00;

        // rst, req, expected gnt, idx, valid, preempt
        tbl.push_back('{1, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 8'hA5, 8'h01, 0, 1, 0});  // fairness 0,2,5,7
        tbl.push_back('{0, 8'hA4, 8'h04, 2, 1, 0});
        tbl.push_back('{0, 8'hA0, 8'h20, 5, 1, 0});
        tbl.push_back('{0, 8'h80, 8'h80, 7, 1, 0});
        tbl.push_back('{0, 8'h81, 8'h80, 7, 1, 0});
        tbl.push_back('{0, 8'h01, 8'h01, 0, 1, 0});  // wrap to 0
        tbl.push_back('{0, 8'h80, 8'h80, 7, 1, 0});
        tbl.push_back('{0, 8'h00, 8'h00, 7, 0, 0});  // idx holds
        tbl.push_back('{0, 8'h03, 8'h01, 0, 1, 0});  // timeout rotation
        tbl.push_back('{0, 8'h03, 8'h01, 0, 1, 0});
        tbl.push_back('{0, 8'h03, 8'h01, 0, 1, 0});
        tbl.push_back('{0, 8'h03, 8'h01, 0, 1, 0});
        tbl.push_back('{0, 8'h03, 8'h02, 1, 1, 1});
        tbl.push_back('{0, 8'h03, 8'h02, 1, 1, 0});
        tbl.push_back('{0, 8'h03, 8'h02, 1, 1, 0});
        tbl.push_back('{0, 8'h03, 8'h02, 1, 1, 0});
        tbl.push_back('{0, 8'h03, 8'h01, 0, 1, 1});
        tbl.push_back('{0, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 8'h01, 8'h01, 0, 1, 0});  // sole requester
        tbl.push_back('{0, 8'h01, 8'h01, 0, 1, 0});
        tbl.push_back('{0, 8'h01, 8'h01, 0, 1, 0});
        tbl.push_back('{0, 8'h01, 8'h01, 0, 1, 0});
        tbl.push_back('{0, 8'h01, 8'h01, 0, 1, 1});
        tbl.push_back('{0, 8'h40, 8'h40, 6, 1, 0});  // owner 6
        tbl.push_back('{1, 8'h41, 8'h00, 0, 0, 0});  // reset mid-grant
        tbl.push_back('{0, 8'h41, 8'h01, 0, 1, 0});  // ptr back to 0
        tbl.push_back('{0, 8'h00, 8'h00, 0, 0, 0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req);
            chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].v, tbl[i].p);
        end

        // Single-request latency, sole-owner re-grant, then release.
        step(1, 8'h00);
        step(0, 8'h00);
        for (int c = 0; c < 5; c++) begin
            step(0, 8'h08);
            chk($sformatf("lat%0d", c), 8'h08, 3'd3, 1'b1, c == 4);
        end
        step(0, 8'h00);
        chk("lat_drop", 8'h00, 3'd3, 1'b0, 1'b0);

        // Randomized traffic against the model.
        step(1, 8'h00);
        m_step(1, 8'h00);
        rq = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rq = rq & 8'($urandom);
            rr = ($urandom_range(0, 99) == 0);
            m_step(rr, rq);
            step(rr, rq);
            chk($sformatf("rnd%0d", c), m_valid ? 8'(1 << m_owner) : 8'h00,
                3'(m_owner), m_valid, m_pre);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
